lives_tracker: RTL and testbench



---
 rtl/game_pkg.sv | 13 +
 rtl/rising_edge_detect.sv | 19 +
 rtl/lives_tracker.sv | 109 ++++++++++
 tb/tb_lives_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-core types and default constants, also used by the game-state controller.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } lives_state_t;

  localparam int DEF_MAX_LIVES     = 3;
  localparam int DEF_INVULN_CYCLES = 25_000_000;

endpackage

// File: rtl/rising_edge_detect.sv
// Level-to-pulse rising-edge detector; rise is combinational from the current input and last sample.
// Previous sample resets high, so a level already asserted at reset release never produces a rise.
module rising_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Rise
);

  logic prev;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) prev <= 1'b1;
    else          prev <= i_Sig;
  end

  assign o_Rise = i_Sig & ~prev;

endmodule

// File: rtl/lives_tracker.sv
// Player-lives manager: hit debounce via invulnerability window, capped bonus lives, game-over.
// Input rise sampled at edge k updates lives/state at edge k; LED and status flags decode registers.
module lives_tracker
  import game_pkg::*;
#(
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int START_LIVES   = 3,
  parameter int INVULN_CYCLES = DEF_INVULN_CYCLES,
  parameter int LIVES_W       = $clog2(MAX_LIVES + 1)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Collided,
  input  logic                 i_Bonus,
  input  logic                 i_Restart,
  output logic [LIVES_W-1:0]   o_Lives,
  output logic [MAX_LIVES-1:0] o_LED,
  output logic                 o_Invulnerable,
  output logic                 o_Life_Lost,
  output logic                 o_Game_Over
);

  localparam int CNT_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = (INVULN_CYCLES > 0) ? CNT_W'(INVULN_CYCLES - 1) : '0;
  localparam logic [LIVES_W-1:0] MAX_L    = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] START_L  = LIVES_W'(START_LIVES);

  if (!(START_LIVES >= 1 && START_LIVES <= MAX_LIVES && MAX_LIVES <= 15)) begin : g_bad_params
    $error("lives_tracker: need 1 <= START_LIVES <= MAX_LIVES <= 15");
  end

  logic coll_rise, bonus_rise, restart_rise;

  rising_edge_detect u_coll_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_Collided),
    .o_Rise  (coll_rise)
  );

  rising_edge_detect u_bonus_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_Bonus),
    .o_Rise  (bonus_rise)
  );

  rising_edge_detect u_restart_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_Restart),
    .o_Rise  (restart_rise)
  );

  lives_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [LIVES_W-1:0] lives;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ALIVE;
      cnt         <= '0;
      lives       <= START_L;
      o_Life_Lost <= 1'b0;
    end else begin
      o_Life_Lost <= 1'b0;
      if (restart_rise) begin
        state <= ALIVE;
        cnt   <= '0;
        lives <= START_L;
      end else begin
        case (state)
          ALIVE: begin
            // An accepted collision swallows a same-cycle bonus.
            if (coll_rise && lives != '0) begin
              lives       <= lives - LIVES_W'(1);
              o_Life_Lost <= 1'b1;
              if (lives == LIVES_W'(1)) begin
                state <= GAME_OVER;
              end else if (INVULN_CYCLES != 0) begin
                state <= INVULN;
                cnt   <= CNT_LOAD;
              end
            end else if (bonus_rise && lives != MAX_L) begin
              lives <= lives + LIVES_W'(1);
            end
          end
          INVULN: begin
            if (cnt == '0) state <= ALIVE;
            else           cnt   <= cnt - CNT_W'(1);
            if (bonus_rise && lives != MAX_L) lives <= lives + LIVES_W'(1);
          end
          GAME_OVER: ;
          default: state <= ALIVE;
        endcase
      end
    end
  end

  always_comb begin
    o_LED = '0;
    for (int i = 0; i < MAX_LIVES; i++) o_LED[i] = (lives > LIVES_W'(i));
  end

  assign o_Lives        = lives;
  assign o_Invulnerable = (state == INVULN);
  assign o_Game_Over    = (state == GAME_OVER);

endmodule

// File: tb/tb_lives_tracker.sv
// Directed self-checking bench for lives_tracker: main instance with a 4-cycle window, second with none.
module tb_lives_tracker;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  logic coll, bonus, restart;
  logic coll2;
  logic [1:0] lives, lives2;
  logic [2:0] led, led2;
  logic inv, lost, go;
  logic inv2, lost2, go2;
  logic inv2_seen;
  int   checks = 0;
  int   errors = 0;

  always #5 i_Clk = ~i_Clk;

  lives_tracker #(.MAX_LIVES(3), .START_LIVES(3), .INVULN_CYCLES(4)) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Collided     (coll),
    .i_Bonus        (bonus),
    .i_Restart      (restart),
    .o_Lives        (lives),
    .o_LED          (led),
    .o_Invulnerable (inv),
    .o_Life_Lost    (lost),
    .o_Game_Over    (go)
  );

  lives_tracker #(.MAX_LIVES(3), .START_LIVES(3), .INVULN_CYCLES(0)) dut0 (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Collided     (coll2),
    .i_Bonus        (1'b0),
    .i_Restart      (1'b0),
    .o_Lives        (lives2),
    .o_LED          (led2),
    .o_Invulnerable (inv2),
    .o_Life_Lost    (lost2),
    .o_Game_Over    (go2)
  );

  always @(negedge i_Clk) if (i_Rst_L && inv2) inv2_seen = 1'b1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1; tick();
    restart = 1'b0; tick();
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0; coll = 1'b1; bonus = 1'b0; restart = 1'b0; coll2 = 1'b0;
    tick(2);
    checks++;
    if (lives !== 2'd3 || led !== 3'b111 || inv !== 1'b0 || go !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_values lives=%0d led=%b inv=%b go=%b lost=%b required 3 111 0 0 0", lives, led, inv, go, lost);
    end
    i_Rst_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (lives !== 2'd3 || led !== 3'b111 || lost !== 1'b0) begin
        errors++;
        $display("FAIL held_collide_at_reset cyc=%0d lives=%0d led=%b lost=%b required 3 111 0", i, lives, led, lost);
      end
    end
    coll = 1'b0; tick();
  endtask

  task automatic test_collision();
    int inv_cnt;
    coll = 1'b1; tick();
    checks++;
    if (lives !== 2'd2 || led !== 3'b011 || lost !== 1'b1 || inv !== 1'b1) begin
      errors++;
      $display("FAIL first_hit lives=%0d led=%b lost=%b inv=%b required 2 011 1 1", lives, led, lost, inv);
    end
    inv_cnt = 1;
    coll = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inv) inv_cnt++;
      checks++;
      if (lost !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse cyc=%0d lost=%b required 0", i, lost);
      end
    end
    checks++;
    if (inv_cnt != 4 || lives !== 2'd2) begin
      errors++;
      $display("FAIL window_length inv_cycles=%0d lives=%0d required 4 2", inv_cnt, lives);
    end
  endtask

  task automatic test_window_ignore();
    pulse_restart();
    coll = 1'b1; tick();
    coll = 1'b0; tick();
    coll = 1'b1; tick();          // fresh rise inside the window
    checks++;
    if (lives !== 2'd2 || lost !== 1'b0 || inv !== 1'b1) begin
      errors++;
      $display("FAIL hit_in_window lives=%0d lost=%b inv=%b required 2 0 1", lives, lost, inv);
    end
    coll = 1'b0; tick();
    coll = 1'b1; tick(3);         // held high across the window end
    checks++;
    if (lives !== 2'd2 || lost !== 1'b0 || inv !== 1'b0) begin
      errors++;
      $display("FAIL held_across_end lives=%0d lost=%b inv=%b required 2 0 0", lives, lost, inv);
    end
    coll = 1'b0; tick();
    coll = 1'b1; tick();
    checks++;
    if (lives !== 2'd1 || lost !== 1'b1) begin
      errors++;
      $display("FAIL new_rise_after lives=%0d lost=%b required 1 1", lives, lost);
    end
    coll = 1'b0; tick(5);
  endtask

  task automatic test_game_over();
    pulse_restart();
    for (int i = 0; i < 3; i++) begin
      coll = 1'b1; tick();
      coll = 1'b0; tick(5);
    end
    checks++;
    if (lives !== 2'd0 || led !== 3'b000 || go !== 1'b1 || inv !== 1'b0) begin
      errors++;
      $display("FAIL game_over lives=%0d led=%b go=%b inv=%b required 0 000 1 0", lives, led, go, inv);
    end
    bonus = 1'b1; tick();
    bonus = 1'b0; tick();
    checks++;
    if (lives !== 2'd0 || go !== 1'b1) begin
      errors++;
      $display("FAIL bonus_in_game_over lives=%0d go=%b required 0 1", lives, go);
    end
    restart = 1'b1; tick();
    checks++;
    if (lives !== 2'd3 || go !== 1'b0 || led !== 3'b111 || lost !== 1'b0) begin
      errors++;
      $display("FAIL restart lives=%0d go=%b led=%b lost=%b required 3 0 111 0", lives, go, led, lost);
    end
    restart = 1'b0; tick();
  endtask

  task automatic test_bonus_and_priority();
    bonus = 1'b1; tick();
    bonus = 1'b0; tick();
    checks++;
    if (lives !== 2'd3) begin
      errors++;
      $display("FAIL bonus_saturate lives=%0d required 3", lives);
    end
    coll = 1'b1; tick();
    coll = 1'b0; tick(5);
    coll = 1'b1; bonus = 1'b1; tick();
    checks++;
    if (lives !== 2'd1 || lost !== 1'b1) begin
      errors++;
      $display("FAIL collide_beats_bonus lives=%0d lost=%b required 1 1", lives, lost);
    end
    coll = 1'b0; bonus = 1'b0; tick();
    bonus = 1'b1; tick();         // bonus still accepted in the window
    checks++;
    if (lives !== 2'd2 || inv !== 1'b1) begin
      errors++;
      $display("FAIL bonus_in_window lives=%0d inv=%b required 2 1", lives, inv);
    end
    bonus = 1'b0; tick(5);
    restart = 1'b1; coll = 1'b1; tick();
    checks++;
    if (lives !== 2'd3 || lost !== 1'b0 || inv !== 1'b0) begin
      errors++;
      $display("FAIL restart_beats_collide lives=%0d lost=%b inv=%b required 3 0 0", lives, lost, inv);
    end
    restart = 1'b0; coll = 1'b0; tick();
  endtask

  task automatic test_reset_mid_window();
    coll = 1'b1; tick();
    coll = 1'b0;
    #2 i_Rst_L = 1'b0;
    #1;
    checks++;
    if (lives !== 2'd3 || inv !== 1'b0 || lost !== 1'b0 || led !== 3'b111) begin
      errors++;
      $display("FAIL async_reset lives=%0d inv=%b lost=%b led=%b required 3 0 0 111", lives, inv, lost, led);
    end
    tick();
    i_Rst_L = 1'b1;
    tick();
  endtask

  task automatic test_no_window();
    inv2_seen = 1'b0;
    coll2 = 1'b1; tick();
    checks++;
    if (lives2 !== 2'd2 || lost2 !== 1'b1 || inv2 !== 1'b0) begin
      errors++;
      $display("FAIL nowin_first lives=%0d lost=%b inv=%b required 2 1 0", lives2, lost2, inv2);
    end
    coll2 = 1'b0; tick();
    coll2 = 1'b1; tick();
    checks++;
    if (lives2 !== 2'd1 || lost2 !== 1'b1 || led2 !== 3'b001) begin
      errors++;
      $display("FAIL nowin_second lives=%0d lost=%b led=%b required 1 1 001", lives2, lost2, led2);
    end
    coll2 = 1'b0; tick(3);
    checks++;
    if (inv2_seen !== 1'b0 || go2 !== 1'b0) begin
      errors++;
      $display("FAIL nowin_never_invuln seen=%b go=%b required 0 0", inv2_seen, go2);
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_window_ignore();
    test_game_over();
    test_bonus_and_priority();
    test_reset_mid_window();
    test_no_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
